ssa_permit_mon: RTL and testbench

- Multi-channel successor to the single-SSA permit monitor. It watches NCH asynchronous SSA enable/permit inputs, where high means healthy.
- Each channel is synchronised, then glitch-filtered with a runtime-programmable qualification count. A qualified fault latches until cleared, and each new trip produces a one-cycle pulse.
- Sits between the SSA digital inputs and the RF-on permit / RF-switch readback logic. It also gives a summary fault flag and, optionally, a first-fault identifier for diagnostics.

---
 rtl/ssa_permit_mon.sv | 151 +++++++++++++++
 tb/tb_ssa_permit_mon.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssa_permit_mon.sv
// Multi-channel SSA permit monitor: sync, glitch-qualify, latch and pulse on trip.
// Optional first-fault capture is enabled by defining SSA_PERMIT_MON_FIRST_FAULT_EN.
module ssa_permit_mon #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [NCH-1:0]   clear_ch,
    input  logic [NCH-1:0]   permit_in,
    input  logic [CNT_W-1:0] thresh,
    output logic [NCH-1:0]   permit_now,
    output logic [NCH-1:0]   permit_latched,
    output logic [NCH-1:0]   trip_pulse,
    output logic             any_fault,
    output logic             first_fault_valid,
    output logic [ID_W-1:0]  first_fault_id
);

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_TRIP = 2'd2;

    logic [NCH-1:0]   sync1_q, sync2_q;
    logic             clear_q;
    logic [NCH-1:0]   clear_ch_q;
    logic [NCH-1:0]   clr;
    logic [1:0]       state_q [NCH];
    logic [1:0]       state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   latched_q, latched_d;
    logic [NCH-1:0]   pulse_q, pulse_d;
    logic             any_fault_q;
    logic [CNT_W-1:0] thr_eff;

    assign thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;
    assign clr     = {NCH{clear_q}} | clear_ch_q;

    // NOTE: every next-state variable gets a default before the case, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clr[i]) begin
                state_d[i] = ST_OK;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_OK: begin
                        if (!sync2_q[i]) begin
                            if (thr_eff == CNT_W'(1)) begin
                                state_d[i] = ST_TRIP;
                            end else begin
                                state_d[i] = ST_PEND;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    ST_PEND: begin
                        if (sync2_q[i]) begin
                            state_d[i] = ST_OK;
                            cnt_d[i]   = '0;
                        end else if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, thr_eff}) begin
                            state_d[i] = ST_TRIP;
                        end else if (cnt_q[i] != '1) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    ST_TRIP: ;
                    default: begin
                        state_d[i] = ST_OK;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            latched_d[i] = (state_d[i] != ST_TRIP);
            pulse_d[i]   = (state_d[i] == ST_TRIP) && (state_q[i] != ST_TRIP);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            clear_q     <= 1'b0;
            clear_ch_q  <= '0;
            latched_q   <= '1;
            pulse_q     <= '0;
            any_fault_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_OK;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= permit_in;
            sync2_q     <= sync1_q;
            clear_q     <= clear;
            clear_ch_q  <= clear_ch;
            latched_q   <= latched_d;
            pulse_q     <= pulse_d;
            any_fault_q <= |(~latched_q);
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef SSA_PERMIT_MON_FIRST_FAULT_EN
    logic            ffv_q;
    logic [ID_W-1:0] ffid_q;
    logic [ID_W-1:0] low_idx;

    // Lowest set pulse index wins when several channels trip together.
    always_comb begin
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pulse_q[i]) low_idx = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ffv_q  <= 1'b0;
            ffid_q <= '0;
        end else if (clear_q) begin
            ffv_q  <= 1'b0;
            ffid_q <= '0;
        end else if (!ffv_q && (|pulse_q)) begin
            ffv_q  <= 1'b1;
            ffid_q <= low_idx;
        end
    end

    assign first_fault_valid = ffv_q;
    assign first_fault_id    = ffid_q;
`else
    assign first_fault_valid = 1'b0;
    assign first_fault_id    = '0;
`endif

    assign permit_now     = sync2_q;
    assign permit_latched = latched_q;
    assign trip_pulse     = pulse_q;
    assign any_fault      = any_fault_q;

endmodule

// File: tb/tb_ssa_permit_mon.sv
// Bench for ssa_permit_mon: expected trip cycles are queued at stimulus time and
// matched against observed trip_pulse bits by a negedge monitor.
module tb_ssa_permit_mon;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int ID_W  = 2;
`ifdef SSA_PERMIT_MON_FIRST_FAULT_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [NCH-1:0]   clear_ch;
    logic [NCH-1:0]   permit_in;
    logic [CNT_W-1:0] thresh;
    logic [NCH-1:0]   permit_now;
    logic [NCH-1:0]   permit_latched;
    logic [NCH-1:0]   trip_pulse;
    logic             any_fault;
    logic             first_fault_valid;
    logic [ID_W-1:0]  first_fault_id;

    ssa_permit_mon #(.NCH(NCH), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .clear             (clear),
        .clear_ch          (clear_ch),
        .permit_in         (permit_in),
        .thresh            (thresh),
        .permit_now        (permit_now),
        .permit_latched    (permit_latched),
        .trip_pulse        (trip_pulse),
        .any_fault         (any_fault),
        .first_fault_valid (first_fault_valid),
        .first_fault_id    (first_fault_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int ch; int at; } exp_t;
    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Scoreboard: every observed pulse must match the oldest queued entry for its channel.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                if (trip_pulse[c]) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (idx < 0 && exp_q[j].ch == c) idx = j;
                    end
                    total++;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse ch%0d at cycle %0d: no trip was expected", c, cyc);
                    end else begin
                        if (exp_q[idx].at != cyc) begin
                            bad++;
                            $display("FAIL pulse_time ch%0d: got cycle %0d, want cycle %0d", c, cyc, exp_q[idx].at);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; clear_ch = '0; permit_in = '1; thresh = 16'd930;
        step(2);
        total++; if (permit_now !== 4'hF) begin bad++; $display("FAIL rst_permit_now: got %h want f", permit_now); end
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL rst_latched: got %h want f", permit_latched); end
        total++; if (trip_pulse !== 4'h0) begin bad++; $display("FAIL rst_pulse: got %h want 0", trip_pulse); end
        total++; if (any_fault !== 1'b0) begin bad++; $display("FAIL rst_any_fault: got %b want 0", any_fault); end
        total++; if (first_fault_valid !== 1'b0 || first_fault_id !== 2'd0) begin
            bad++; $display("FAIL rst_first_fault: got v=%b id=%0d want v=0 id=0", first_fault_valid, first_fault_id);
        end
        reset = 1'b0;
        step(3);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL post_rst_latched: got %h want f", permit_latched); end
    endtask

    task automatic test_qualified_trip();
        int k;
        thresh = 16'h03A2;
        step(1);
        k = cyc;
        permit_in[1] = 1'b0;
        exp_q.push_back('{1, k + 932});
        step(931);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL qt_before: got %h want f", permit_latched); end
        step(1);
        total++; if (permit_latched !== 4'b1101) begin bad++; $display("FAIL qt_latched: got %h want d", permit_latched); end
        total++; if (trip_pulse !== 4'b0010) begin bad++; $display("FAIL qt_pulse: got %h want 2", trip_pulse); end
        total++; if (any_fault !== 1'b0) begin bad++; $display("FAIL qt_any_early: got %b want 0", any_fault); end
        step(1);
        total++; if (trip_pulse !== 4'h0) begin bad++; $display("FAIL qt_pulse_width: got %h want 0", trip_pulse); end
        total++; if (any_fault !== 1'b1) begin bad++; $display("FAIL qt_any_fault: got %b want 1", any_fault); end
        step(67);
        permit_in[1] = 1'b1;
        step(3);
        pulse_clear();
        total++; if (permit_latched !== 4'hF || any_fault !== 1'b0) begin
            bad++; $display("FAIL qt_cleared: got latched=%h any=%b want f/0", permit_latched, any_fault);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL qt_pending: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        int k;
        k = cyc;
        permit_in[0] = 1'b0;
        step(1);
        total++; if (permit_now[0] !== 1'b1) begin bad++; $display("FAIL gl_now_lat1: got %b want 1", permit_now[0]); end
        step(1);
        total++; if (permit_now[0] !== 1'b0) begin bad++; $display("FAIL gl_now_lat2: got %b want 0", permit_now[0]); end
        step(927);
        permit_in[0] = 1'b1;
        step(1);
        total++; if (permit_now[0] !== 1'b0) begin bad++; $display("FAIL gl_now_rise1: got %b want 0", permit_now[0]); end
        step(1);
        total++; if (permit_now[0] !== 1'b1) begin bad++; $display("FAIL gl_now_rise2: got %b want 1", permit_now[0]); end
        step(10);
        total++; if (permit_latched !== 4'hF || any_fault !== 1'b0) begin
            bad++; $display("FAIL gl_no_trip: got latched=%h any=%b want f/0", permit_latched, any_fault);
        end
        k = cyc;
        permit_in[0] = 1'b0;
        exp_q.push_back('{0, k + 932});
        step(930);
        permit_in[0] = 1'b1;
        step(2);
        total++; if (permit_latched !== 4'b1110) begin bad++; $display("FAIL gl_trip930: got %h want e", permit_latched); end
        step(3);
        pulse_clear();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL gl_pending: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_clear_semantics();
        int k, k2;
        k = cyc;
        permit_in[2] = 1'b0;
        exp_q.push_back('{2, k + 932});
        step(932);
        total++; if (permit_latched[2] !== 1'b0) begin bad++; $display("FAIL cs_trip: got %b want 0", permit_latched[2]); end
        step(5);
        clear_ch[2] = 1'b1;
        k2 = cyc;
        step(1);
        clear_ch = '0;
        exp_q.push_back('{2, k2 + 932});
        step(1);
        total++; if (permit_latched[2] !== 1'b1) begin bad++; $display("FAIL cs_cleared: got %b want 1", permit_latched[2]); end
        step(929);
        total++; if (permit_latched[2] !== 1'b1) begin bad++; $display("FAIL cs_requal: got %b want 1", permit_latched[2]); end
        step(1);
        total++; if (permit_latched[2] !== 1'b0 || trip_pulse[2] !== 1'b1) begin
            bad++; $display("FAIL cs_retrip: got latched=%b pulse=%b want 0/1", permit_latched[2], trip_pulse[2]);
        end
        permit_in[2] = 1'b1;
        step(3);
        clear_ch[2] = 1'b1;
        step(1);
        clear_ch = '0;
        step(30);
        total++; if (permit_latched !== 4'hF || any_fault !== 1'b0) begin
            bad++; $display("FAIL cs_healthy: got latched=%h any=%b want f/0", permit_latched, any_fault);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cs_pending: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        int k;
        logic           v_exp;
        logic [ID_W-1:0] id_exp;
        v_exp  = FF_EN;
        id_exp = FF_EN ? 2'd1 : 2'd0;
        thresh = 16'd5;
        step(1);
        k = cyc;
        permit_in = 4'b0101;
        exp_q.push_back('{3, k + 7});
        exp_q.push_back('{1, k + 7});
        step(7);
        total++; if (trip_pulse !== 4'b1010) begin bad++; $display("FAIL sim_pulses: got %h want a", trip_pulse); end
        step(1);
        total++; if (first_fault_valid !== v_exp || first_fault_id !== id_exp) begin
            bad++; $display("FAIL sim_capture: got v=%b id=%0d want v=%b id=%0d", first_fault_valid, first_fault_id, v_exp, id_exp);
        end
        k = cyc;
        permit_in[0] = 1'b0;
        exp_q.push_back('{0, k + 7});
        step(8);
        total++; if (permit_latched !== 4'b0100) begin bad++; $display("FAIL sim_latched: got %h want 4", permit_latched); end
        total++; if (first_fault_valid !== v_exp || first_fault_id !== id_exp) begin
            bad++; $display("FAIL sim_hold: got v=%b id=%0d want v=%b id=%0d", first_fault_valid, first_fault_id, v_exp, id_exp);
        end
        permit_in = '1;
        step(3);
        clear_ch = 4'b1011;
        step(1);
        clear_ch = '0;
        step(3);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL sim_chclr: got %h want f", permit_latched); end
        total++; if (first_fault_valid !== v_exp || first_fault_id !== id_exp) begin
            bad++; $display("FAIL sim_chclr_keep: got v=%b id=%0d want v=%b id=%0d", first_fault_valid, first_fault_id, v_exp, id_exp);
        end
        pulse_clear();
        total++; if (first_fault_valid !== 1'b0 || first_fault_id !== 2'd0) begin
            bad++; $display("FAIL sim_gclr: got v=%b id=%0d want v=0 id=0", first_fault_valid, first_fault_id);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sim_pending: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_clear_coincident();
        int k;
        k = cyc;
        permit_in[1] = 1'b0;
        exp_q.push_back('{1, k + 12});
        step(5);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL cc_no_trip: got %h want f", permit_latched); end
        step(4);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL cc_requal: got %h want f", permit_latched); end
        step(1);
        total++; if (permit_latched !== 4'b1101) begin bad++; $display("FAIL cc_late_trip: got %h want d", permit_latched); end
        permit_in[1] = 1'b1;
        step(3);
        pulse_clear();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cc_pending: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_edge_cases();
        int k;
        thresh = 16'd0;
        step(1);
        k = cyc;
        permit_in[2] = 1'b0;
        exp_q.push_back('{2, k + 3});
        step(2);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL ec_t0_early: got %h want f", permit_latched); end
        step(1);
        total++; if (permit_latched !== 4'b1011) begin bad++; $display("FAIL ec_t0_trip: got %h want b", permit_latched); end
        permit_in[2] = 1'b1;
        step(3);
        pulse_clear();

        thresh = 16'd930;
        permit_in[0] = 1'b0;
        step(100);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (permit_now !== 4'hF || permit_latched !== 4'hF || trip_pulse !== 4'h0 || any_fault !== 1'b0) begin
            bad++; $display("FAIL ec_rst_pend: got now=%h lat=%h pulse=%h any=%b want f/f/0/0", permit_now, permit_latched, trip_pulse, any_fault);
        end
        permit_in = '1;
        step(3);
        reset = 1'b0;
        step(5);
        total++; if (permit_latched !== 4'hF) begin bad++; $display("FAIL ec_rel_pend: got %h want f", permit_latched); end

        thresh = 16'd3;
        step(1);
        k = cyc;
        permit_in[3] = 1'b0;
        exp_q.push_back('{3, k + 5});
        step(8);
        total++; if (permit_latched !== 4'b0111 || any_fault !== 1'b1) begin
            bad++; $display("FAIL ec_trip3: got lat=%h any=%b want 7/1", permit_latched, any_fault);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (permit_now !== 4'hF || permit_latched !== 4'hF || trip_pulse !== 4'h0 || any_fault !== 1'b0) begin
            bad++; $display("FAIL ec_rst_trip: got now=%h lat=%h pulse=%h any=%b want f/f/0/0", permit_now, permit_latched, trip_pulse, any_fault);
        end
        total++; if (first_fault_valid !== 1'b0 || first_fault_id !== 2'd0) begin
            bad++; $display("FAIL ec_rst_ff: got v=%b id=%0d want v=0 id=0", first_fault_valid, first_fault_id);
        end
        permit_in = '1;
        step(2);
        reset = 1'b0;
        step(10);
        total++; if (permit_latched !== 4'hF || any_fault !== 1'b0) begin
            bad++; $display("FAIL ec_rel_trip: got lat=%h any=%b want f/0", permit_latched, any_fault);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ec_pending: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_qualified_trip();
        test_glitch();
        test_clear_semantics();
        test_simultaneous();
        test_clear_coincident();
        test_edge_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
